// File: rtl/npu_pkg.sv
// Shared NPU definitions: Q8.8 element width, derived beat/keep widths and the
// readout FSM state encoding.
package npu_pkg;

  localparam int Q88_WIDTH  = 16;
  localparam int BEAT_WIDTH = 2 * Q88_WIDTH;
  localparam int KEEP_WIDTH = BEAT_WIDTH / 8;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RUN  = 2'd1,
    RD_DONE = 2'd2
  } readout_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; exposes the two oldest entries so the
// consumer can pop one or two elements per cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       pop_n,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain modular arithmetic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop_n);
    end
  end

  assign rd_data0 = mem[rd_ptr];
  assign rd_data1 = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/output_readout_ctrl.sv
// Output buffer readout: issues credit-limited reads, packs element pairs into
// AXI-Stream beats. Optional stall counter under OUTPUT_READOUT_STALL_CNT_EN.
// Handshake: a beat transfers on a rising clk edge with m_tvalid && m_tready;
// while m_tvalid is high and m_tready low, m_tdata/m_tkeep/m_tlast hold.
module output_readout_ctrl
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = Q88_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int SKID_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH:0]       length,
  output logic                      busy,
  output logic                      done,
  output logic                      buf_rd_en,
  output logic [ADDR_WIDTH-1:0]     buf_rd_addr,
  input  logic [DATA_WIDTH-1:0]     buf_rd_data,
  input  logic                      buf_rd_valid,
  output logic [2*DATA_WIDTH-1:0]   m_tdata,
  output logic [2*DATA_WIDTH/8-1:0] m_tkeep,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast
`ifdef OUTPUT_READOUT_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cycles
`endif
);

  localparam int KW = 2 * DATA_WIDTH / 8;
  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam int LW = ADDR_WIDTH + 1;

  readout_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         issued_q;
  logic [LW-1:0]         popped_q;
  logic                  inflight_q;

  logic                  fifo_push;
  logic [1:0]            pop_n;
  logic [DATA_WIDTH-1:0] fifo_d0;
  logic [DATA_WIDTH-1:0] fifo_d1;
  logic [CW-1:0]         fifo_count;

  logic          start_acc;
  logic          beat_hs;
  logic          credit_ok;
  logic          reg_free;
  logic          load_full;
  logic          load_tail;
  logic [LW-1:0] elem_n;

  assign start_acc = (state_q == RD_IDLE) && start;
  assign beat_hs   = m_tvalid && m_tready;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign credit_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(SKID_DEPTH);
  assign buf_rd_en   = (state_q == RD_RUN) && (issued_q < len_q) && credit_ok;
  assign buf_rd_addr = base_q + issued_q[ADDR_WIDTH-1:0];

  assign fifo_push = buf_rd_valid && (state_q == RD_RUN);

  assign reg_free  = !m_tvalid || m_tready;
  assign load_full = (state_q == RD_RUN) && reg_free && (fifo_count >= CW'(2));
  assign load_tail = (state_q == RD_RUN) && reg_free && (fifo_count == CW'(1)) &&
                     (popped_q == len_q - LW'(1));
  assign pop_n     = load_full ? 2'd2 : (load_tail ? 2'd1 : 2'd0);
  assign elem_n    = LW'(pop_n);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .wr_data  (buf_rd_data),
    .pop_n    (pop_n),
    .rd_data0 (fifo_d0),
    .rd_data1 (fifo_d1),
    .count    (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    busy    = (state_q != RD_IDLE);
    done    = (state_q == RD_DONE);
    unique case (state_q)
      RD_IDLE: if (start) state_d = (length == '0) ? RD_DONE : RD_RUN;
      RD_RUN:  if (beat_hs && m_tlast) state_d = RD_DONE;
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= buf_rd_en;
      if (start_acc) begin
        base_q   <= base_addr;
        len_q    <= length;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (buf_rd_en) issued_q <= issued_q + LW'(1);
        popped_q <= popped_q + elem_n;
      end
    end
  end

  // Output register: refilled in the same cycle it hands off, so back-to-back beats need no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else if (load_full || load_tail) begin
      m_tvalid <= 1'b1;
      m_tdata  <= load_full ? {fifo_d1, fifo_d0} : {{DATA_WIDTH{1'b0}}, fifo_d0};
      m_tkeep  <= load_full ? {KW{1'b1}} : {{(KW/2){1'b0}}, {(KW/2){1'b1}}};
      m_tlast  <= (popped_q + elem_n) == len_q;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

`ifdef OUTPUT_READOUT_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cycles <= '0;
    end else if (m_tvalid && !m_tready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/output_readout_ctrl.md
Name: output_readout_ctrl

Overview:
- Downstream consumer of the output buffer. Takes a start/base/length command and issues synchronous reads into the buffer's read port, absorbing the buffer's 1-cycle read latency.
- Packs pairs of 16-bit Q8.8 results into 32-bit beats on an AXI-Stream-style master toward the AXI interface / host.
- Tolerates arbitrary m_tready backpressure without losing or duplicating elements.

Parameters:
- DATA_WIDTH, 16, element width (beat width = 2*DATA_WIDTH).
- ADDR_WIDTH, 8, buffer address width; buffer depth = 2**ADDR_WIDTH.
- SKID_DEPTH, 4, element FIFO depth; power of 2, >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  command strobe; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first element address.
- length  in  ADDR_WIDTH+1  element count, 0..2**ADDR_WIDTH.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- buf_rd_en  out  1  buffer read enable.
- buf_rd_addr  out  ADDR_WIDTH  buffer read address.
- buf_rd_data  in  DATA_WIDTH  buffer data, valid when buf_rd_valid.
- buf_rd_valid  in  1  asserted 1 cycle after buf_rd_en.
- m_tdata  out  2*DATA_WIDTH  packed beat; element k in [15:0], element k+1 in [31:16].
- m_tkeep  out  2*DATA_WIDTH/8  byte enables.
- m_tvalid  out  1  beat valid.
- m_tready  in  1  sink ready.
- m_tlast  out  1  final beat of the command.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FIFO emptied, counters 0, state IDLE. Reset mid-transfer abandons the transfer; buf_rd_valid in the following cycle is ignored.
- FSM states:
  - IDLE: start with length=0 → DONE. start with length>0 → RUN; latch base_addr and length, zero issue/beat counters.
  - RUN: on the cycle the last beat handshakes (m_tvalid && m_tready && m_tlast) → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored. busy = (state != IDLE).
- Read issue:
  - In RUN, buf_rd_en=1 when issued < length and (fifo_count + inflight) < SKID_DEPTH. inflight = buf_rd_en registered one cycle.
  - buf_rd_addr = base_addr + issued, modulo 2**ADDR_WIDTH (wraps 255→0).
- FIFO push: on buf_rd_valid while in RUN. Overflow is impossible by the credit rule.
- Beat formation (output register):
  - Load a beat when the register is empty or handshaking this cycle, and either the FIFO holds >= 2 elements, or it holds 1 element that is the final element of an odd length.
  - m_tkeep: 4'b1111 for full beats; 4'b0011 with upper half 0 for the odd tail beat.
  - m_tlast = 1 on beat ceil(length/2)-1.
- AXI-Stream rules: once m_tvalid=1, m_tdata, m_tkeep and m_tlast hold until m_tready. Sustained throughput is 1 beat per 2 cycles (limited by 1 read/cycle).
- Latency: start accepted at cycle 0 → first buf_rd_en at cycle 1 → first m_tvalid no earlier than cycle 4.
- Length 2**ADDR_WIDTH reads every address exactly once.

Optional Feature:
- Macro OUTPUT_READOUT_STALL_CNT_EN.
- Defined: adds output stall_cycles (16 bits). It counts cycles with m_tvalid && !m_tready, saturates at 16'hFFFF, clears to 0 on start acceptance and on rst, and holds its value after done.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package npu_pkg holds:
  - Q8.8 element width constant.
  - Beat width and keep width constants.
  - readout FSM state enum (IDLE/RUN/DONE).
- One natural sub-module: sync_fifo (parameterised width/depth, count output), instantiated as the element skid FIFO. Packer and FSM stay in the top module.

Test Plan:
- base=0x10, length=4, m_tready=1 → reads 0x10..0x13; 2 beats {e1,e0},{e3,e2}; tkeep=F; tlast on beat 2; done pulse 1 cycle later.
- base=0xFE, length=3 → addresses FE,FF,00; beat 2 = {16'h0,e2}, tkeep=4'b0011, tlast=1.
- length=256, m_tready toggling randomly (50%) → 128 beats, data matches buffer contents in order, no duplicates, tdata stable while stalled, fifo never exceeds SKID_DEPTH.
- length=0 → no buf_rd_en, no m_tvalid, done asserted the cycle after start; second start during RUN ignored.
- rst asserted mid-transfer at beat 5 of 64 → all outputs 0 next cycle; a new start with length=2 completes correctly.
- With OUTPUT_READOUT_STALL_CNT_EN: length=4, m_tready held low 7 cycles after first m_tvalid → stall_cycles=7 at done.
